hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Multi-cycle divide sequencer for the EX stage. Accepts DIV/DIVU operands and runs a 32-step restoring division.
- Holds the pipeline via stallreq while busy.
- Issues a single write to the HI/LO register file: quotient to LO, remainder to HI.
- Sole sequencer of HI/LO writes for divide operations.

Parameters:
DATA_W, 32, operand width; HI/LO width; number of division steps

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  request to begin a divide; sampled each rising edge
annul  in  1  cancel the current/requested divide (branch flush or exception)
signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
opdata1  in  DATA_W  dividend
opdata2  in  DATA_W  divisor
stallreq  out  1  pipeline hold request
ready  out  1  result valid, one-cycle pulse
hilo_we  out  1  HI/LO write enable, one-cycle pulse, equal to ready
whi  out  DATA_W  remainder, written to HI
wlo  out  DATA_W  quotient, written to LO

Behaviour:
- Reset: rst=1 sampled at a rising edge forces state IDLE, clears counter, dividend register and result registers. All outputs read 0 from the following cycle. Reset mid-operation abandons the divide with no HI/LO write.
- States: IDLE, BYZERO, ON, END (2-bit encoding).
- IDLE:
  - start=1, annul=0, opdata2==0 -> BYZERO.
  - start=1, annul=0, opdata2!=0 -> ON. Operands latched; counter=0.
  - Signed mode: operands are latched as absolute values; sign of quotient (opdata1[MSB]^opdata2[MSB]) and sign of remainder (opdata1[MSB]) are latched.
  - Otherwise stay in IDLE.
- ON:
  - Each cycle performs one restoring step on a (2*DATA_W+1)-bit working register: shift left 1, trial-subtract divisor from the upper half. If non-negative, keep the difference and set quotient bit 1; else quotient bit 0.
  - Counter increments each step. After step DATA_W (counter reaches DATA_W) -> END, with sign correction applied when entering END:
    - quotient negated if the quotient sign is set;
    - remainder negated if the dividend sign is set.
  - annul=1 in ON -> IDLE on that edge; no write.
- BYZERO: next edge -> END with quotient=0, remainder=0. annul=1 -> IDLE instead.
- END: ready=1 and hilo_we=1 for exactly this cycle; whi/wlo valid; stallreq=0. Next edge -> IDLE unconditionally, even if start remains high.
- stallreq (combinational) = (IDLE & start & ~annul) | BYZERO | ON.
- start in BYZERO/ON/END is ignored. Operand changes after acceptance have no effect.
- whi/wlo hold their last result in IDLE. They are don't-care for HI/LO because hilo_we=0 outside END.
- Latency, counting the acceptance edge as E0:
  - normal divide: ready high in the cycle after E(DATA_W), i.e. 33 cycles of stall (the IDLE request cycle plus 32 ON cycles);
  - divide-by-zero: ready in the cycle after E1.
- Arithmetic is modulo 2^DATA_W. Signed most-negative / -1 yields quotient 0x80000000, remainder 0, with no trap.
- Simultaneous start and annul in IDLE: annul wins, stay IDLE, stallreq=0.

Decomposition:
- Shared defines package, extended with:
  - state encodings DivIdle, DivByZero, DivOn, DivEnd;
  - DoubleRegBus width;
  - DivResultReady/NotReady, DivStart/DivStop constants;
  - existing DataBus, ZeroWord, Enable/Disable.
- One natural sub-module, div_step: combinational single restoring step (shift, trial subtract, quotient bit), instantiated once and driven by the working register.

Test Plan:
- Unsigned 100/7, signed_div=0 -> stallreq high 33 cycles. Then one-cycle hilo_we with wlo=14 and whi=2; back to IDLE the next cycle.
- Signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> wlo=0xFFFFFFFD, whi=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> wlo=0x80000000, whi=0x00000000, no hang.
- 5/0 -> stallreq high 2 cycles; ready/hilo_we in the cycle after E1 with whi=wlo=0.
- Start 0xFFFFFFFF / 3 unsigned, then annul=1 at the 10th ON cycle -> IDLE next edge, stallreq low, hilo_we never asserted. A following 9/3 yields wlo=3, whi=0.
- rst=1 at the 20th ON cycle of 1000/10 -> all outputs 0, no hilo_we. start held high through END gives exactly one hilo_we pulse per accepted start.

Source files
------------

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: bus widths, control
// constants and divider state encodings.
package hilo_div_ctrl_pkg;

    localparam int DataBusW      = 32;
    localparam int DoubleRegBusW = 2 * DataBusW;

    localparam logic [DataBusW-1:0] ZeroWord = '0;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivIdle   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// EX-stage <-> divider handshake: operands and control in, stall and HI/LO
// write port out.
interface hilo_div_ctrl_if
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DATA_W = DataBusW
);
    logic              start;
    logic              annul;
    logic              signed_div;
    logic [DATA_W-1:0] opdata1;
    logic [DATA_W-1:0] opdata2;
    logic              stallreq;
    logic              ready;
    logic              hilo_we;
    logic [DATA_W-1:0] whi;
    logic [DATA_W-1:0] wlo;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  stallreq, ready, hilo_we, whi, wlo
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output stallreq, ready, hilo_we, whi, wlo
    );
endinterface

// File: rtl/hilo_div_ctrl_div_step.sv
// One restoring-division step on the {remainder, quotient} working register.
module hilo_div_ctrl_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  work,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  work_next
);
    logic [2*DATA_W:0] shifted;
    logic [DATA_W+1:0] trial;

    // The partial remainder is always below the divisor, so after the shift
    // the upper half fits in DATA_W+1 bits; one more bit carries the borrow.
    always_comb begin
        shifted = work << 1;
        trial   = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, divisor};
        if (!trial[DATA_W+1]) begin
            work_next = {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
        end else begin
            work_next = shifted;
        end
    end
endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: stalls the pipeline while dividing and
// issues one HI/LO write (remainder -> HI, quotient -> LO).
//
//   state     | meaning
//   DivIdle   | waiting for start; results hold last value
//   DivByZero | divisor was zero; result forced to 0 next edge
//   DivOn     | one restoring step per cycle, DATA_W steps
//   DivEnd    | result valid, single HI/LO write pulse
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DATA_W = DataBusW
) (
    input  logic           clk,
    input  logic           rst,
    hilo_div_ctrl_if.slave bus
);
    localparam int WORK_W = 2 * DATA_W + 1;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORK_W-1:0] work_q, work_next;
    logic [DATA_W-1:0] divisor_q, whi_q, wlo_q;
    logic              quo_neg_q, rem_neg_q;

    logic              dividend_neg, divisor_neg, accept, divisor_zero;
    logic [DATA_W-1:0] dividend_abs, divisor_abs, quo_raw, rem_raw;

    assign dividend_neg = bus.signed_div & bus.opdata1[DATA_W-1];
    assign divisor_neg  = bus.signed_div & bus.opdata2[DATA_W-1];
    assign dividend_abs = dividend_neg ? -bus.opdata1 : bus.opdata1;
    assign divisor_abs  = divisor_neg  ? -bus.opdata2 : bus.opdata2;
    assign divisor_zero = (bus.opdata2 == '0);
    assign accept       = (state_q == DivIdle) && (bus.start == DivStart)
                          && (bus.annul == Disable);

    assign quo_raw = work_next[DATA_W-1:0];
    assign rem_raw = work_next[2*DATA_W-1:DATA_W];

    hilo_div_ctrl_div_step #(.DATA_W(DATA_W)) u_div_step (
        .work      (work_q),
        .divisor   (divisor_q),
        .work_next (work_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DivIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DivIdle: begin
                if (accept) begin
                    state_d = divisor_zero ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = (bus.annul == Enable) ? DivIdle : DivEnd;
            DivOn: begin
                if (bus.annul == Enable) begin
                    state_d = DivIdle;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = DivEnd;
                end
            end
            DivEnd:  state_d = DivIdle;
            default: state_d = DivIdle;
        endcase
    end

    // Datapath: operands are captured as magnitudes, signs applied on the
    // final step so the result registers only change when a write is due.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            whi_q     <= '0;
            wlo_q     <= '0;
        end else begin
            case (state_q)
                DivIdle: begin
                    if (accept && !divisor_zero) begin
                        cnt_q     <= '0;
                        work_q    <= {{(DATA_W + 1){1'b0}}, dividend_abs};
                        divisor_q <= divisor_abs;
                        quo_neg_q <= dividend_neg ^ divisor_neg;
                        rem_neg_q <= dividend_neg;
                    end
                end
                DivByZero: begin
                    if (bus.annul == Disable) begin
                        whi_q <= DATA_W'(ZeroWord);
                        wlo_q <= DATA_W'(ZeroWord);
                    end
                end
                DivOn: begin
                    if (bus.annul == Disable) begin
                        work_q <= work_next;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            wlo_q <= quo_neg_q ? -quo_raw : quo_raw;
                            whi_q <= rem_neg_q ? -rem_raw : rem_raw;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.stallreq = accept || (state_q == DivByZero) || (state_q == DivOn);
        bus.ready    = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
        bus.hilo_we  = (state_q == DivEnd) ? Enable : Disable;
        bus.whi      = whi_q;
        bus.wlo      = wlo_q;
    end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed corner cases plus random
// divides checked against a magnitude/sign arithmetic model.
module tb_hilo_div_ctrl;
    import hilo_div_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    hilo_div_ctrl_if #(.DATA_W(32)) bus ();

    hilo_div_ctrl #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Truncating division on magnitudes, quotient sign = xor of operand signs,
    // remainder sign = dividend sign; divide-by-zero yields zeros.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
        logic na, nb;
        logic [DoubleRegBusW-1:0] ma, mb;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
        mb = nb ? (64'd4294967296 - {32'd0, b}) : {32'd0, b};
        if (mb == 0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = 32'(ma / mb);
            r = 32'(ma % mb);
            if (na ^ nb) q = -q;
            if (na) r = -r;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = DivStop; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++; if (bus.stallreq !== 1'b0) $display("FAIL reset_stallreq actual=%b required=0", bus.stallreq); else passed++;
        total++; if (bus.ready !== 1'b0) $display("FAIL reset_ready actual=%b required=0", bus.ready); else passed++;
        total++; if (bus.hilo_we !== 1'b0) $display("FAIL reset_hilo_we actual=%b required=0", bus.hilo_we); else passed++;
        total++; if (bus.whi !== 32'd0) $display("FAIL reset_whi actual=%h required=0", bus.whi); else passed++;
        total++; if (bus.wlo !== 32'd0) $display("FAIL reset_wlo actual=%h required=0", bus.wlo); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_divide(input logic [31:0] a, input logic [31:0] b,
                               input logic sgn, input logic hold, input string name);
        logic [31:0] eq, er;
        int stalls, exp_stalls, pulses;
        bit done;
        model(a, b, sgn, eq, er);
        exp_stalls = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        bus.start = DivStart; bus.annul = 1'b0; bus.signed_div = sgn;
        bus.opdata1 = a; bus.opdata2 = b;
        #1;
        stalls = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (bus.hilo_we === 1'b1) begin
                done = 1'b1;
                total++; if (bus.ready !== 1'b1) $display("FAIL %s ready actual=%b required=1", name, bus.ready); else passed++;
                total++; if (bus.wlo !== eq) $display("FAIL %s wlo actual=%h required=%h", name, bus.wlo, eq); else passed++;
                total++; if (bus.whi !== er) $display("FAIL %s whi actual=%h required=%h", name, bus.whi, er); else passed++;
                total++; if (bus.stallreq !== 1'b0) $display("FAIL %s end_stallreq actual=%b required=0", name, bus.stallreq); else passed++;
                total++; if (stalls !== exp_stalls) $display("FAIL %s stall_cycles actual=%0d required=%0d", name, stalls, exp_stalls); else passed++;
            end else begin
                if (bus.stallreq === 1'b1) stalls++;
                @(negedge clk);
                if (!hold) begin
                    bus.start = DivStop;
                    bus.signed_div = 1'($urandom);
                    bus.opdata1 = $urandom;
                    bus.opdata2 = $urandom;
                end
                #1;
            end
        end
        if (!done) begin
            total++;
            $display("FAIL %s timeout hilo_we actual=0 required=1 within 100 cycles", name);
            return;
        end
        @(negedge clk); #1;
        total++; if (bus.hilo_we !== 1'b0) $display("FAIL %s after_end_hilo_we actual=%b required=0", name, bus.hilo_we); else passed++;
        if (hold) begin
            bus.start = DivStop;
            pulses = 0;
            repeat (40) begin
                @(negedge clk); #1;
                if (bus.hilo_we === 1'b1) pulses++;
            end
            total++; if (pulses !== 0) $display("FAIL %s extra_pulses actual=%0d required=0", name, pulses); else passed++;
        end else begin
            total++; if (bus.stallreq !== 1'b0) $display("FAIL %s after_end_stallreq actual=%b required=0", name, bus.stallreq); else passed++;
            total++; if (bus.wlo !== eq) $display("FAIL %s wlo_hold actual=%h required=%h", name, bus.wlo, eq); else passed++;
        end
    endtask

    task automatic test_annul();
        int pulses;
        @(negedge clk);
        bus.start = DivStart; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = 32'hFFFF_FFFF; bus.opdata2 = 32'd3;
        @(negedge clk);
        bus.start = DivStop;
        repeat (9) @(negedge clk);
        bus.annul = 1'b1; #1;
        total++; if (bus.stallreq !== 1'b1) $display("FAIL annul_on_stallreq actual=%b required=1", bus.stallreq); else passed++;
        @(negedge clk);
        bus.annul = 1'b0; #1;
        total++; if (bus.stallreq !== 1'b0) $display("FAIL annul_idle_stallreq actual=%b required=0", bus.stallreq); else passed++;
        pulses = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (bus.hilo_we === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL annul_hilo_we pulses actual=%0d required=0", pulses); else passed++;
        test_divide(32'd9, 32'd3, 1'b0, 1'b0, "after_annul_9_3");
    endtask

    task automatic test_start_annul_idle();
        @(negedge clk);
        bus.start = DivStart; bus.annul = 1'b1; bus.signed_div = 1'b0;
        bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; #1;
        total++; if (bus.stallreq !== 1'b0) $display("FAIL start_annul_stallreq actual=%b required=0", bus.stallreq); else passed++;
        @(negedge clk);
        bus.start = DivStop; bus.annul = 1'b0; #1;
        total++; if (bus.stallreq !== 1'b0) $display("FAIL start_annul_next_stallreq actual=%b required=0", bus.stallreq); else passed++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        bus.start = DivStart; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = 32'd1000; bus.opdata2 = 32'd10;
        @(negedge clk);
        bus.start = DivStop;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        total++; if (bus.stallreq !== 1'b0) $display("FAIL rst_mid_stallreq actual=%b required=0", bus.stallreq); else passed++;
        total++; if (bus.ready !== 1'b0) $display("FAIL rst_mid_ready actual=%b required=0", bus.ready); else passed++;
        total++; if (bus.whi !== 32'd0) $display("FAIL rst_mid_whi actual=%h required=0", bus.whi); else passed++;
        total++; if (bus.wlo !== 32'd0) $display("FAIL rst_mid_wlo actual=%h required=0", bus.wlo); else passed++;
        pulses = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (bus.hilo_we === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL rst_mid_hilo_we pulses actual=%0d required=0", pulses); else passed++;
        test_divide(32'd1000, 32'd10, 1'b0, 1'b0, "after_reset_1000_10");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic sgn;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            sgn = 1'($urandom);
            test_divide(a, b, sgn, 1'b0, $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_divide(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        test_divide(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, "div_m7_2");
        test_divide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_minint_m1");
        test_divide(32'd5, 32'd0, 1'b0, 1'b0, "div_by_zero");
        test_annul();
        test_start_annul_idle();
        test_reset_mid();
        test_divide(32'd77, 32'd8, 1'b0, 1'b1, "start_held");
        test_divide(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "div_max_minint");
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
